fetch_pc_ctrl: RTL and testbench

//  Sink side of the ID-stage operand comparator. Takes the equality flag (cmp_eq), the

---
 rtl/fetch_pc_ctrl_pkg.sv | 52 +++++
 rtl/fetch_pc_ctrl_npc_calc.sv | 40 ++++
 rtl/fetch_pc_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: branch/jump type codes,
// controller states, reset fetch address and the branch condition helper.
package fetch_pc_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned BRT_W   = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned INDEX_W = 26;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;

  // Branch/jump type codes, shared with the decoder
  typedef enum logic [BRT_W-1:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLEZ = 4'd3,
    BR_BGTZ = 4'd4,
    BR_BLTZ = 4'd5,
    BR_BGEZ = 4'd6,
    BR_J    = 4'd7,
    BR_JAL  = 4'd8,
    BR_JR   = 4'd9,
    BR_JALR = 4'd10
  } br_type_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } pc_state_e;

  // Taken condition for a type code, ignoring whether a decision is made this cycle
  function automatic logic br_cond(input logic [BRT_W-1:0] br_type,
                                   input logic             cmp_eq,
                                   input logic [XLEN-1:0]  rs_val);
    logic rs_zero;
    logic rs_neg;
    rs_zero = (rs_val == '0);
    rs_neg  = rs_val[XLEN-1];
    case (br_type)
      BR_BEQ:  br_cond = cmp_eq;
      BR_BNE:  br_cond = ~cmp_eq;
      BR_BLEZ: br_cond = rs_neg | rs_zero;
      BR_BGTZ: br_cond = ~rs_neg & ~rs_zero;
      BR_BLTZ: br_cond = rs_neg;
      BR_BGEZ: br_cond = ~rs_neg;
      BR_J, BR_JAL, BR_JR, BR_JALR: br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_npc_calc.sv
// Next-PC target and link address computation for the ID-stage instruction.
// Purely combinational.
//   id_pc, id_imm16, id_index, rs_val, id_br_type -> target, link_addr
module fetch_pc_ctrl_npc_calc
  import fetch_pc_ctrl_pkg::*;
(
  input  logic [XLEN-1:0]    id_pc,
  input  logic [IMM_W-1:0]   id_imm16,
  input  logic [INDEX_W-1:0] id_index,
  input  logic [XLEN-1:0]    rs_val,
  input  logic [BRT_W-1:0]   id_br_type,
  output logic [XLEN-1:0]    target,
  output logic [XLEN-1:0]    link_addr
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;

  assign pc_plus4  = id_pc + XLEN'(4);
  assign link_addr = id_pc + XLEN'(8);

  // Sign-extended word offset, relative to the delay-slot address
  assign br_off = {{14{id_imm16[IMM_W-1]}}, id_imm16, 2'b00};
  assign br_tgt = pc_plus4 + br_off;

  // Region jump keeps the top nibble of the delay-slot address
  assign j_tgt = {pc_plus4[XLEN-1:XLEN-4], id_index, 2'b00};

  always_comb begin
    target = br_tgt;
    case (id_br_type)
      BR_J, BR_JAL:   target = j_tgt;
      BR_JR, BR_JALR: target = rs_val;
      default:        target = br_tgt;
    endcase
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC owner. Resolves the ID-stage branch/jump decision and loads the
// fetch PC with the next address; parks a resolved target while fetch is stalled.
// Ports:
//   clk, reset (async, active-high)
//   stall_id, stall_f             hazard stall / instruction memory wait
//   id_valid, id_br_type, id_pc,  ID instruction description
//   id_imm16, id_index
//   cmp_eq, rs_val                forwarded comparator result and rs operand
//   pc_f                          current fetch address (registered)
//   link_addr                     id_pc + 8 (combinational)
//   redirect                      pulse: pc_f was just loaded from a target
//   pend                          a target is parked awaiting fetch
//   tgt_misalign                  pulse: misaligned register-jump target taken
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_id,
  input  logic               stall_f,
  input  logic               id_valid,
  input  logic [BRT_W-1:0]   id_br_type,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [IMM_W-1:0]   id_imm16,
  input  logic [INDEX_W-1:0] id_index,
  input  logic               cmp_eq,
  input  logic [XLEN-1:0]    rs_val,
  output logic [XLEN-1:0]    pc_f,
  output logic [XLEN-1:0]    link_addr,
  output logic               redirect,
  output logic               pend,
  output logic               tgt_misalign
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] target;
  logic            decide;
  logic            taken;
  logic            reg_jump;
  logic            misalign_c;

  fetch_pc_ctrl_npc_calc u_npc_calc (
    .id_pc      (id_pc),
    .id_imm16   (id_imm16),
    .id_index   (id_index),
    .rs_val     (rs_val),
    .id_br_type (id_br_type),
    .target     (target),
    .link_addr  (link_addr)
  );

  // Decision qualification
  assign decide     = id_valid & ~stall_id;
  assign taken      = decide & br_cond(id_br_type, cmp_eq, rs_val);
  assign reg_jump   = (id_br_type == BR_JR) | (id_br_type == BR_JALR);
  assign misalign_c = taken & reg_jump & (rs_val[1:0] != 2'b00);

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        // stall_id wins: decision inputs are not valid, fetch wait is irrelevant
        if (!stall_id) begin
          if (taken) begin
            misalign_d = misalign_c;
            if (stall_f) begin
              pend_pc_d = target;
              state_d   = ST_PEND;
            end else begin
              pc_d       = target;
              redirect_d = 1'b1;
            end
          end else if (!stall_f) begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      ST_PEND: begin
        // First parked target wins; further decisions here are ignored
        if (!stall_f) begin
          pc_d       = pend_pc_q;
          redirect_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_f         = pc_q;
  assign redirect     = redirect_q;
  assign pend         = (state_q == ST_PEND);
  assign tgt_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_id;
  logic        stall_f;
  logic        id_valid;
  logic [3:0]  id_br_type;
  logic [31:0] id_pc;
  logic [15:0] id_imm16;
  logic [25:0] id_index;
  logic        cmp_eq;
  logic [31:0] rs_val;
  logic [31:0] pc_f;
  logic [31:0] link_addr;
  logic        redirect;
  logic        pend;
  logic        tgt_misalign;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] T_NONE = 4'd0, T_BEQ = 4'd1, T_BNE = 4'd2, T_BLEZ = 4'd3,
                         T_BGTZ = 4'd4, T_J = 4'd7, T_JAL = 4'd8, T_JR = 4'd9,
                         T_JALR = 4'd10;

  fetch_pc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall_id     (stall_id),
    .stall_f      (stall_f),
    .id_valid     (id_valid),
    .id_br_type   (id_br_type),
    .id_pc        (id_pc),
    .id_imm16     (id_imm16),
    .id_index     (id_index),
    .cmp_eq       (cmp_eq),
    .rs_val       (rs_val),
    .pc_f         (pc_f),
    .link_addr    (link_addr),
    .redirect     (redirect),
    .pend         (pend),
    .tgt_misalign (tgt_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs after one clock: pc_f, redirect, pend, tgt_misalign
  task automatic chk_st(input string tag, input logic [31:0] pc, input logic rd,
                        input logic pd, input logic ma);
    chk({tag, ".pc_f"}, pc_f, pc);
    chk({tag, ".redirect"}, 32'(redirect), 32'(rd));
    chk({tag, ".pend"}, 32'(pend), 32'(pd));
    chk({tag, ".misalign"}, 32'(tgt_misalign), 32'(ma));
  endtask

  // Advance one clock; never present a real decision while a target is parked
  task automatic tick();
    chk("no_decision_in_pend", 32'(pend & id_valid & ~stall_id & (id_br_type != T_NONE)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] t, input logic [31:0] pc,
                        input logic [15:0] imm, input logic [25:0] idx,
                        input logic eq, input logic [31:0] rs);
    id_valid = v; id_br_type = t; id_pc = pc; id_imm16 = imm;
    id_index = idx; cmp_eq = eq; rs_val = rs;
  endtask

  initial begin
    reset = 1'b1; stall_id = 1'b0; stall_f = 1'b0;
    set_id(1'b0, T_NONE, 32'h0, 16'h0, 26'h0, 1'b0, 32'h0);
    #1;
    chk_st("reset", 32'h0000_3000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_st("reset_rel", 32'h0000_3000, 1'b0, 1'b0, 1'b0);

    // Sequential fetch
    set_id(1'b1, T_NONE, 32'h0000_3000, 16'h0, 26'h0, 1'b0, 32'h0);
    tick(); chk_st("seq1", 32'h0000_3004, 1'b0, 1'b0, 1'b0);
    tick(); chk_st("seq2", 32'h0000_3008, 1'b0, 1'b0, 1'b0);

    // BEQ backward, taken then not taken
    set_id(1'b1, T_BEQ, 32'h0000_3010, 16'hFFFC, 26'h0, 1'b1, 32'h0);
    #1 chk("link_beq", link_addr, 32'h0000_3018);
    tick(); chk_st("beq_taken", 32'h0000_3004, 1'b1, 1'b0, 1'b0);
    set_id(1'b1, T_BEQ, 32'h0000_3010, 16'hFFFC, 26'h0, 1'b0, 32'h0);
    tick(); chk_st("beq_not", 32'h0000_3008, 1'b0, 1'b0, 1'b0);

    // Sign-test boundaries and region jump
    set_id(1'b1, T_BGTZ, 32'h0000_3000, 16'h0004, 26'h0, 1'b0, 32'h0);
    tick(); chk_st("bgtz_zero", 32'h0000_300C, 1'b0, 1'b0, 1'b0);
    set_id(1'b1, T_BLEZ, 32'h0000_3000, 16'h0004, 26'h0, 1'b0, 32'h8000_0000);
    tick(); chk_st("blez_neg", 32'h0000_3014, 1'b1, 1'b0, 1'b0);
    set_id(1'b1, T_J, 32'h0000_3020, 16'h0, 26'h000_0C10, 1'b0, 32'h0);
    tick(); chk_st("j", 32'h0000_3040, 1'b1, 1'b0, 1'b0);

    // JR misaligned, parked under fetch stall for 3 cycles
    stall_f = 1'b1;
    set_id(1'b1, T_JR, 32'h0000_3038, 16'h0, 26'h0, 1'b0, 32'h0000_3102);
    tick(); chk_st("jr_park", 32'h0000_3040, 1'b0, 1'b1, 1'b1);
    set_id(1'b0, T_NONE, 32'h0, 16'h0, 26'h0, 1'b0, 32'h0);
    tick(); chk_st("jr_hold2", 32'h0000_3040, 1'b0, 1'b1, 1'b0);
    tick(); chk_st("jr_hold3", 32'h0000_3040, 1'b0, 1'b1, 1'b0);
    stall_f = 1'b0;
    tick(); chk_st("jr_load", 32'h0000_3102, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("jr_after", 32'h0000_3106, 1'b0, 1'b0, 1'b0);

    // JALR misaligned, loaded directly
    set_id(1'b1, T_JALR, 32'h0000_3100, 16'h0, 26'h0, 1'b0, 32'h0000_2001);
    #1 chk("link_jalr", link_addr, 32'h0000_3108);
    tick(); chk_st("jalr", 32'h0000_2001, 1'b1, 1'b0, 1'b1);

    // stall_id holds pc_f even with fetch free and a taken BNE presented
    stall_id = 1'b1;
    set_id(1'b1, T_BNE, 32'h0000_3100, 16'h0010, 26'h0, 1'b0, 32'h0);
    tick(); chk_st("sid_hold1", 32'h0000_2001, 1'b0, 1'b0, 1'b0);
    tick(); chk_st("sid_hold2", 32'h0000_2001, 1'b0, 1'b0, 1'b0);
    stall_id = 1'b0;
    tick(); chk_st("sid_rel", 32'h0000_3144, 1'b1, 1'b0, 1'b0);

    // JAL parked, then async reset discards it
    stall_f = 1'b1;
    set_id(1'b1, T_JAL, 32'h0000_3140, 16'h0, 26'h000_0100, 1'b0, 32'h0);
    #1 chk("link_jal", link_addr, 32'h0000_3148);
    tick(); chk_st("jal_park", 32'h0000_3144, 1'b0, 1'b1, 1'b0);
    set_id(1'b0, T_NONE, 32'h0, 16'h0, 26'h0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1 chk_st("async_rst", 32'h0000_3000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    stall_f = 1'b0;
    tick(); chk_st("post_rst1", 32'h0000_3004, 1'b0, 1'b0, 1'b0);
    tick(); chk_st("post_rst2", 32'h0000_3008, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
